fifo_ctrl: RTL and testbench

- Control side of the 8-entry × 12-bit FIFO memory.
- Owns the write/read pointers and write/read strobes that drive the memory, replacing the externally driven pointers used during memory bring-up.
- Accepts push/pop requests from the upstream/downstream logic and tracks occupancy.
- Raises full/empty/almost flags, a read-data valid strobe aligned to the memory's registered read, and a sticky error flag.

---
 rtl/fifo_ctrl.sv | 88 ++++++++
 tb/tb_fifo_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Control side of an 8 x 12 FIFO memory: owns the write/read pointers and strobes,
// tracks occupancy, decodes status flags, and aligns a valid strobe to the memory's registered q.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  write,
  output logic                  read,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  valid_out,
  output logic                  error
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_valid;
  logic                  r_error;

  logic w_full;
  logic w_empty;
  logic w_write;
  logic w_read;
  logic w_reject;

  // Handshake: push/pop are requests sampled every cycle; a request is accepted
  // (write/read high) only when there is room/data and reset is low. There is
  // no bypass, and a full FIFO with push+pop accepts only the pop.
  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_write  = push & ~w_full & ~reset;
  assign w_read   = pop & ~w_empty & ~reset;
  assign w_reject = (push & w_full) | (pop & w_empty);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_read)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_valid <= w_read;
      if (w_reject) r_error <= 1'b1;
    end
  end

  assign data         = data_in;
  assign wr_ptr       = r_wr_ptr;
  assign rd_ptr       = r_rd_ptr;
  assign write        = w_write;
  assign read         = w_read;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign valid_out    = r_valid;
  assign error        = r_error;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios plus random push/pop traffic against a
// queue-based reference model, with a behavioural memory attached to the strobes.
module tb_fifo_ctrl;

  localparam int DW = 12;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          write;
  logic          read;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          valid_out;
  logic          error;

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data(data), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .write(write), .read(read),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .valid_out(valid_out), .error(error)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory the controller drives
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_q;
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= data;
    if (read)  mem_q <= mem[rd_ptr];
  end

  // reference model
  logic [DW-1:0] exp_q[$];
  int            m_writes;
  int            m_reads;
  bit            m_err;
  bit            m_valid;
  logic [DW-1:0] m_word;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_writes = 0;
    m_reads  = 0;
    m_err    = 1'b0;
    m_valid  = 1'b0;
  endtask

  task automatic check_state();
    int sz;
    sz = exp_q.size();
    check_val("wr_ptr", 32'(wr_ptr), 32'(m_writes % DEPTH));
    check_val("rd_ptr", 32'(rd_ptr), 32'(m_reads % DEPTH));
    check_val("count", 32'(count), 32'(sz));
    check_val("full", 32'(full), 32'(sz == DEPTH));
    check_val("empty", 32'(empty), 32'(sz == 0));
    check_val("almost_full", 32'(almost_full), 32'(sz >= 6));
    check_val("almost_empty", 32'(almost_empty), 32'(sz <= 2));
    check_val("error", 32'(error), 32'(m_err));
    check_val("valid_out", 32'(valid_out), 32'(m_valid));
  endtask

  // driver: one clock of push/pop, checked before and after the edge
  task automatic step(input bit p, input bit o, input logic [DW-1:0] d);
    bit exp_w, exp_r;
    int sz;
    @(negedge clk);
    push = p; pop = o; data_in = d;
    #1;
    sz    = exp_q.size();
    exp_w = p && (sz < DEPTH);
    exp_r = o && (sz > 0);
    check_val("write", 32'(write), 32'(exp_w));
    check_val("read", 32'(read), 32'(exp_r));
    check_val("data", 32'(data), 32'(d));
    check_state();
    @(posedge clk);
    if ((p && sz == DEPTH) || (o && sz == 0)) m_err = 1'b1;
    if (exp_r) begin
      m_word = exp_q.pop_front();
      m_reads++;
    end
    if (exp_w) begin
      exp_q.push_back(d);
      m_writes++;
    end
    m_valid = exp_r;
    #1;
    check_state();
    if (m_valid) check_val("q_order", 32'(mem_q), 32'(m_word));
  endtask

  // asynchronous reset asserted mid-cycle with requests active
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1; push = 1'b1; pop = 1'b1;
    #1;
    model_clear();
    check_val("rst_write", 32'(write), 32'd0);
    check_val("rst_read", 32'(read), 32'd0);
    check_state();
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    reset = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  logic [DW-1:0] basic_tbl [4] = '{12'h123, 12'hABC, 12'h456, 12'hDEF};

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    model_clear();
    #1;
    check_state();
    #20;
    @(negedge clk);
    reset = 1'b0;

    // underflow from reset
    step(1'b0, 1'b1, 12'h000);

    // reset mid-operation with count = 3 and error set
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'(i + 1));
    do_reset();

    // basic ordering
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, basic_tbl[i]);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 12'h000);
    step(1'b0, 1'b0, 12'h000);

    // fill, overflow, push+pop at full, drain through every threshold
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 12'($urandom));
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 12'($urandom));
    step(1'b1, 1'b1, 12'hFFF);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 12'h000);

    // push+pop at empty
    do_reset();
    step(1'b1, 1'b1, 12'h5A5);
    step(1'b0, 1'b1, 12'h000);

    // steady push+pop at count 4 across pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 12'($urandom));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 12'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 12'h000);

    // random traffic, occasionally reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
